ddr4_reset_n_seq: RTL and testbench

DDR4_RESET_N_SEQ -- requirements
Module: ddr4_reset_n_seq

---
 rtl/ddr4_reset_n_seq.sv | 153 +++++++++++++++
 tb/tb_ddr4_reset_n_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_reset_n_seq.sv
// DDR4 RESET_N / CKE power-up sequencer feeding a 4:1 RESET_N output IOD.
// Define DDR4_RESET_DELAY_TRIM_EN to build the DONE-state delay-line trim handshake.
module ddr4_reset_n_seq #(
   parameter int HOLD_CYC = 33334,
   parameter int CKE_CYC  = 83334,
   parameter int LOAD_CYC = 4,
   parameter int CNT_W    = 20
) (
   input  logic       FAB_CLK,
   input  logic       ARST,
   input  logic       START,
   input  logic       DELAY_LINE_OUT_OF_RANGE,
   input  logic       TRIM_REQ,
   input  logic       TRIM_DIR,
   output logic [3:0] TX_DATA,
   output logic [3:0] OE_DATA,
   output logic       DELAY_LINE_LOAD,
   output logic       DELAY_LINE_MOVE,
   output logic       DELAY_LINE_DIRECTION,
   output logic       TRIM_ACK,
   output logic       TRIM_ERR,
   output logic       CKE_EN,
   output logic       INIT_DONE
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HOLD,
      S_WAIT_CKE,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CKE_LAST  = CNT_W'(CKE_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [3:0]       tx_q, tx_d;
   logic [3:0]       oe_q, oe_d;
   logic             load_q, load_d;
   logic             cke_q, cke_d;
   logic             done_q, done_d;
   logic             move_q, move_d;
   logic             dir_q, dir_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             load_entry;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:     if (START) state_d = S_LOAD;
         S_LOAD:     if (timer_q == LOAD_LAST) state_d = S_HOLD;
         S_HOLD:     if (timer_q == HOLD_LAST) state_d = S_WAIT_CKE;
         S_WAIT_CKE: begin
            if (START)                     state_d = S_LOAD;
            else if (timer_q == CKE_LAST)  state_d = S_DONE;
         end
         S_DONE:     if (START) state_d = S_LOAD;
         default:    state_d = S_IDLE;
      endcase
   end

   assign load_entry = (state_d == S_LOAD) && (state_q != S_LOAD);

   // Timer only runs in the timed states and restarts from zero on every entry.
   always_comb begin
      timer_d = '0;
      if ((state_d == state_q) &&
          ((state_q == S_LOAD) || (state_q == S_HOLD) || (state_q == S_WAIT_CKE)))
         timer_d = timer_q + CNT_W'(1);
   end

   always_comb begin
      tx_d = tx_q;
      case (state_d)
         S_IDLE, S_HOLD:     tx_d = 4'h0;
         S_WAIT_CKE, S_DONE: tx_d = 4'hF;
         default:            tx_d = tx_q;
      endcase
      oe_d   = {4{state_d != S_IDLE}};
      load_d = (state_d == S_LOAD);
      cke_d  = (state_d == S_DONE);
      done_d = (state_d == S_DONE);
   end

`ifdef DDR4_RESET_DELAY_TRIM_EN
   logic trim_fire;

   // START in DONE takes priority over a pending trim request.
   always_comb begin
      trim_fire = (state_q == S_DONE) && !START && TRIM_REQ && !ack_q;
      ack_d     = trim_fire;
      move_d    = trim_fire && !DELAY_LINE_OUT_OF_RANGE;
      dir_d     = trim_fire ? TRIM_DIR : dir_q;
      err_d     = err_q | (trim_fire & DELAY_LINE_OUT_OF_RANGE);
      if (load_entry)
         err_d = 1'b0;
   end
`else
   logic unused_trim_inputs;

   assign unused_trim_inputs = ^{TRIM_REQ, TRIM_DIR, DELAY_LINE_OUT_OF_RANGE, load_entry};

   always_comb begin
      ack_d  = 1'b0;
      move_d = 1'b0;
      dir_d  = 1'b0;
      err_d  = 1'b0;
   end
`endif

   always_ff @(posedge FAB_CLK or posedge ARST) begin
      if (ARST) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         tx_q    <= 4'h0;
         oe_q    <= 4'h0;
         load_q  <= 1'b0;
         cke_q   <= 1'b0;
         done_q  <= 1'b0;
         move_q  <= 1'b0;
         dir_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         tx_q    <= tx_d;
         oe_q    <= oe_d;
         load_q  <= load_d;
         cke_q   <= cke_d;
         done_q  <= done_d;
         move_q  <= move_d;
         dir_q   <= dir_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   assign TX_DATA              = tx_q;
   assign OE_DATA              = oe_q;
   assign DELAY_LINE_LOAD      = load_q;
   assign DELAY_LINE_MOVE      = move_q;
   assign DELAY_LINE_DIRECTION = dir_q;
   assign TRIM_ACK             = ack_q;
   assign TRIM_ERR             = err_q;
   assign CKE_EN               = cke_q;
   assign INIT_DONE            = done_q;

endmodule

// File: tb/tb_ddr4_reset_n_seq.sv
// Scoreboard bench for ddr4_reset_n_seq: expected output vectors are queued per cycle
// and popped/compared one time unit after each rising edge.
`timescale 1ns/1ps
module tb_ddr4_reset_n_seq;

   localparam int HOLD_CYC = 10;
   localparam int CKE_CYC  = 20;
   localparam int LOAD_CYC = 4;
   localparam int CNT_W    = 20;
`ifdef DDR4_RESET_DELAY_TRIM_EN
   localparam logic TRIM_EN = 1'b1;
`else
   localparam logic TRIM_EN = 1'b0;
`endif

   localparam logic [14:0] MASK_ALL   = 15'h7FFF;
   localparam logic [14:0] MASK_NODIR = 15'h7FEF;
   localparam logic [14:0] MASK_NOTX  = 15'h07EF;

   logic       FAB_CLK = 1'b0;
   logic       ARST = 1'b1;
   logic       START = 1'b0;
   logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
   logic       TRIM_REQ = 1'b0;
   logic       TRIM_DIR = 1'b0;
   logic [3:0] TX_DATA, OE_DATA;
   logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
   logic       TRIM_ACK, TRIM_ERR, CKE_EN, INIT_DONE;
   logic [14:0] obs;

   typedef struct {
      logic [14:0] exp;
      logic [14:0] mask;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   logic exp_err = 1'b0;

   ddr4_reset_n_seq #(
      .HOLD_CYC(HOLD_CYC),
      .CKE_CYC (CKE_CYC),
      .LOAD_CYC(LOAD_CYC),
      .CNT_W   (CNT_W)
   ) dut (
      .FAB_CLK                (FAB_CLK),
      .ARST                   (ARST),
      .START                  (START),
      .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
      .TRIM_REQ               (TRIM_REQ),
      .TRIM_DIR               (TRIM_DIR),
      .TX_DATA                (TX_DATA),
      .OE_DATA                (OE_DATA),
      .DELAY_LINE_LOAD        (DELAY_LINE_LOAD),
      .DELAY_LINE_MOVE        (DELAY_LINE_MOVE),
      .DELAY_LINE_DIRECTION   (DELAY_LINE_DIRECTION),
      .TRIM_ACK               (TRIM_ACK),
      .TRIM_ERR               (TRIM_ERR),
      .CKE_EN                 (CKE_EN),
      .INIT_DONE              (INIT_DONE)
   );

   always #5 FAB_CLK = ~FAB_CLK;

   assign obs = {TX_DATA, OE_DATA, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
                 TRIM_ACK, TRIM_ERR, CKE_EN, INIT_DONE};

   function automatic logic [14:0] ev(input logic [3:0] tx, input logic [3:0] oe, input logic ld,
                                      input logic mv, input logic dir, input logic ack,
                                      input logic err, input logic cd);
      return {tx, oe, ld, mv, dir, ack, err, cd, cd};
   endfunction

   task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (tx,oe,ld,mv,dir,ack,err,cke,done)", tag, got, exp);
      end
   endtask

   task automatic pop_chk();
      exp_t e;
      if (sb_q.size() == 0) begin
         $display("FAIL sb_underflow: got empty scoreboard expected an entry");
         $fatal(1, "scoreboard underflow");
      end
      e = sb_q.pop_front();
      check_eq(e.tag, obs & e.mask, e.exp & e.mask);
   endtask

   task automatic tick(input logic [14:0] exp, input logic [14:0] mask, input string tag);
      sb_q.push_back('{exp: exp, mask: mask, tag: tag});
      @(posedge FAB_CLK);
      #1;
      pop_chk();
   endtask

   task automatic now_chk(input logic [14:0] exp, input logic [14:0] mask, input string tag);
      sb_q.push_back('{exp: exp, mask: mask, tag: tag});
      #1;
      pop_chk();
   endtask

   // START tick, LOAD, HOLD (optional TRIM_REQ for the first hold_trim cycles), WAIT_CKE, first DONE cycle.
   task automatic run_seq(input string tag, input logic start_trim, input logic tx_known,
                          input int hold_trim);
      logic [14:0] lm;
      lm       = tx_known ? MASK_NODIR : MASK_NOTX;
      exp_err  = 1'b0;
      START    = 1'b1;
      TRIM_REQ = start_trim;
      TRIM_DIR = 1'b1;
      tick(ev(4'h0, 4'hF, 1, 0, 0, 0, 0, 0), lm, {tag, "_load0"});
      START    = 1'b0;
      TRIM_REQ = 1'b0;
      for (int i = 1; i < LOAD_CYC; i++)
         tick(ev(4'h0, 4'hF, 1, 0, 0, 0, 0, 0), lm, {tag, "_load"});
      for (int i = 0; i < HOLD_CYC; i++) begin
         TRIM_REQ = (i < hold_trim);
         tick(ev(4'h0, 4'hF, 0, 0, 0, 0, 0, 0), MASK_NODIR, {tag, "_hold"});
      end
      TRIM_REQ = 1'b0;
      for (int i = 0; i < CKE_CYC; i++)
         tick(ev(4'hF, 4'hF, 0, 0, 0, 0, 0, 0), MASK_NODIR, {tag, "_wait"});
      tick(ev(4'hF, 4'hF, 0, 0, 0, 0, 0, 1), MASK_NODIR, {tag, "_done"});
   endtask

   initial begin
      // Power-on reset and idle behaviour.
      #3;
      now_chk(ev(4'h0, 4'h0, 0, 0, 0, 0, 0, 0), MASK_ALL, "reset_vals");
      tick(ev(4'h0, 4'h0, 0, 0, 0, 0, 0, 0), MASK_ALL, "reset_hold");
      ARST = 1'b0;
      TRIM_REQ = 1'b1;
      TRIM_DIR = 1'b1;
      for (int i = 0; i < 3; i++)
         tick(ev(4'h0, 4'h0, 0, 0, 0, 0, 0, 0), MASK_ALL, "idle_no_start");
      TRIM_REQ = 1'b0;

      run_seq("basic", 1'b0, 1'b1, 8);
      tick(ev(4'hF, 4'hF, 0, 0, 0, 0, 0, 1), MASK_NODIR, "done_stay");

      // Trim handshake in DONE.
      TRIM_REQ = 1'b1;
      TRIM_DIR = 1'b1;
      tick(ev(4'hF, 4'hF, 0, TRIM_EN, TRIM_EN, TRIM_EN, 0, 1), MASK_ALL, "trim_up");
      TRIM_REQ = 1'b0;
      tick(ev(4'hF, 4'hF, 0, 0, 0, 0, 0, 1), MASK_NODIR, "trim_release");
      TRIM_REQ = 1'b1;
      TRIM_DIR = 1'b0;
      for (int i = 0; i < 4; i++)
         tick(ev(4'hF, 4'hF, 0, TRIM_EN & ~i[0], 1'b0, TRIM_EN & ~i[0], 0, 1),
              i[0] ? MASK_NODIR : MASK_ALL, "trim_held");
      TRIM_REQ = 1'b0;
      tick(ev(4'hF, 4'hF, 0, 0, 0, 0, 0, 1), MASK_NODIR, "trim_gap");
      DELAY_LINE_OUT_OF_RANGE = 1'b1;
      TRIM_REQ = 1'b1;
      TRIM_DIR = 1'b1;
      tick(ev(4'hF, 4'hF, 0, 0, TRIM_EN, TRIM_EN, TRIM_EN, 1), MASK_ALL, "trim_oor");
      exp_err = TRIM_EN;
      TRIM_REQ = 1'b0;
      DELAY_LINE_OUT_OF_RANGE = 1'b0;
      for (int i = 0; i < 3; i++)
         tick(ev(4'hF, 4'hF, 0, 0, 0, 0, exp_err, 1), MASK_NODIR, "err_sticky");

      // START together with TRIM_REQ in DONE: restart wins, error cleared on LOAD entry.
      run_seq("start_trim", 1'b1, 1'b0, 0);
      run_seq("restart", 1'b0, 1'b0, 0);

      // Asynchronous reset in the middle of HOLD; START during HOLD is ignored.
      START = 1'b1;
      tick(ev(4'h0, 4'hF, 1, 0, 0, 0, 0, 0), MASK_NOTX, "rst_seq_load0");
      START = 1'b0;
      for (int i = 1; i < LOAD_CYC; i++)
         tick(ev(4'h0, 4'hF, 1, 0, 0, 0, 0, 0), MASK_NOTX, "rst_seq_load");
      for (int i = 0; i < 5; i++) begin
         START = (i == 2);
         tick(ev(4'h0, 4'hF, 0, 0, 0, 0, 0, 0), MASK_NODIR, "hold_ignore_start");
      end
      START = 1'b0;
      #1;
      ARST = 1'b1;
      now_chk(ev(4'h0, 4'h0, 0, 0, 0, 0, 0, 0), MASK_ALL, "arst_in_hold");
      tick(ev(4'h0, 4'h0, 0, 0, 0, 0, 0, 0), MASK_ALL, "arst_held");
      ARST = 1'b0;
      for (int i = 0; i < 4; i++)
         tick(ev(4'h0, 4'h0, 0, 0, 0, 0, 0, 0), MASK_ALL, "post_arst_idle");

      // START during WAIT_CKE restarts at LOAD.
      START = 1'b1;
      tick(ev(4'h0, 4'hF, 1, 0, 0, 0, 0, 0), MASK_ALL, "w_load0");
      START = 1'b0;
      for (int i = 1; i < LOAD_CYC; i++)
         tick(ev(4'h0, 4'hF, 1, 0, 0, 0, 0, 0), MASK_ALL, "w_load");
      for (int i = 0; i < HOLD_CYC; i++)
         tick(ev(4'h0, 4'hF, 0, 0, 0, 0, 0, 0), MASK_ALL, "w_hold");
      for (int i = 0; i < 3; i++)
         tick(ev(4'hF, 4'hF, 0, 0, 0, 0, 0, 0), MASK_ALL, "w_wait");
      START = 1'b1;
      tick(ev(4'h0, 4'hF, 1, 0, 0, 0, 0, 0), MASK_NOTX, "wait_restart");
      START = 1'b0;
      for (int i = 1; i < LOAD_CYC; i++)
         tick(ev(4'h0, 4'hF, 1, 0, 0, 0, 0, 0), MASK_NOTX, "wait_restart_load");
      tick(ev(4'h0, 4'hF, 0, 0, 0, 0, 0, 0), MASK_ALL, "wait_restart_hold");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
